module_keypad_scanner: RTL and testbench

- 4x4 matrix keypad scanner and decoder for the Teclado design. Sits downstream of the scan-tick clock divider and consumes its one-cycle enable pulse.
- Drives one active-low column per tick and samples the rows. Debounces press and release, then presents a 4-bit key code to the consumer with a valid/ack handshake.
- All logic runs on one 10 MHz clock. scan_tick_i is an enable, never a clock.

---
 rtl/module_keypad_scanner.sv | 210 +++++++++++++++++++++
 tb/tb_module_keypad_scanner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_keypad_scanner.sv
// -----------------------------------------------------------------------------
// module_keypad_scanner
//   4x4 matrix keypad scanner/decoder. Walks an active-low column strobe one
//   step per scan tick, samples the (synchronized) rows, debounces press and
//   release over DEBOUNCE_TICKS ticks and hands the decoded key to a consumer
//   through a level valid / pulse ack handshake.
//
// Ports
//   clk_10Mhz_i  in   system clock (10 MHz)
//   reset_i      in   asynchronous, active-high reset
//   scan_tick_i  in   one-cycle enable; scan/debounce advance only when high
//   row_i[3:0]   in   keypad rows, active-low, asynchronous to the clock
//   key_ack_i    in   consumer acknowledge, clears key_valid_o
//   col_o[3:0]   out  column drive, active-low, exactly one bit low
//   key_code_o   out  last accepted key, row_idx*4 + col_idx
//   key_valid_o  out  high from key acceptance until acknowledged
//   key_down_o   out  high while a key is held or its release is debounced
//   overrun_o    out  (only with KEYPAD_OVERRUN_FLAG_EN) sticky flag, set when
//                     a key is accepted over an unacknowledged one
//
// Optional feature macro: KEYPAD_OVERRUN_FLAG_EN
// -----------------------------------------------------------------------------
module module_keypad_scanner #(
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic       clk_10Mhz_i,
   input  logic       reset_i,
   input  logic       scan_tick_i,
   input  logic [3:0] row_i,
   input  logic       key_ack_i,
   output logic [3:0] col_o,
   output logic [3:0] key_code_o,
   output logic       key_valid_o,
   output logic       key_down_o
`ifdef KEYPAD_OVERRUN_FLAG_EN
   ,
   output logic       overrun_o
`endif
);

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DB,
      HOLD,
      REL_DB
   } state_t;

   localparam logic [3:0] DB_TICKS = 4'(DEBOUNCE_TICKS);

   state_t     state_q, state_d;
   logic [1:0] col_idx_q, col_idx_d;
   logic [3:0] row_latch_q, row_latch_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;
   logic [3:0] sync1_q, sync2_q;

   logic [3:0] row_s;
   logic [3:0] row_low;
   logic       row_s_valid;
   logic [1:0] row_s_idx;
   logic [3:0] cnt_inc;
   logic       accept;

   function automatic logic [1:0] low_index(input logic [3:0] rows);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Two-flop synchronizer for the asynchronous row inputs
   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= row_i;
         sync2_q <= sync1_q;
      end
   end

   assign row_s   = sync2_q;
   assign row_low = ~row_s;
   // Exactly one row low: non-zero and a power of two
   assign row_s_valid = (row_low != '0) && ((row_low & (row_low - 4'd1)) == '0);
   assign row_s_idx   = low_index(row_s);
   assign cnt_inc     = cnt_q + 4'd1;

   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= SCAN;
         col_idx_q   <= '0;
         row_latch_q <= '1;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_latch_q <= row_latch_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      row_latch_d = row_latch_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;

      if (scan_tick_i) begin
         case (state_q)
            SCAN: begin
               if (row_s_valid) begin
                  row_latch_d = row_s;
                  cnt_d       = 4'd1;
                  // A single-tick debounce accepts on the detection tick
                  if (DB_TICKS == 4'd1) begin
                     state_d = HOLD;
                     accept  = 1'b1;
                  end else begin
                     state_d = PRESS_DB;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            PRESS_DB: begin
               if (row_s == row_latch_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_TICKS) begin
                     state_d = HOLD;
                     accept  = 1'b1;
                  end
               end else begin
                  state_d   = SCAN;
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
            HOLD: begin
               if (row_s == 4'b1111) begin
                  cnt_d = 4'd1;
                  if (DB_TICKS == 4'd1) begin
                     state_d   = SCAN;
                     col_idx_d = col_idx_q + 2'd1;
                  end else begin
                     state_d = REL_DB;
                  end
               end
            end
            REL_DB: begin
               if (row_s == 4'b1111) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_TICKS) begin
                     state_d   = SCAN;
                     col_idx_d = col_idx_q + 2'd1;
                  end
               end else begin
                  state_d = HOLD;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // Acceptance has priority over a coincident acknowledge
   always_comb begin
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
      if (accept) begin
         key_valid_d = 1'b1;
         key_code_d  = {row_s_idx, col_idx_q};
      end else if (key_ack_i) begin
         key_valid_d = 1'b0;
      end
   end

`ifdef KEYPAD_OVERRUN_FLAG_EN
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q;
      if (accept && key_valid_q && !key_ack_i) begin
         overrun_d = 1'b1;
      end else if (!accept && key_ack_i && key_valid_q) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) overrun_q <= 1'b0;
      else         overrun_q <= overrun_d;
   end

   assign overrun_o = overrun_q;
`endif

   assign col_o       = ~(4'b0001 << col_idx_q);
   assign key_code_o  = key_code_q;
   assign key_valid_o = key_valid_q;
   assign key_down_o  = (state_q == HOLD) || (state_q == REL_DB);

endmodule

// File: tb/tb_module_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_module_keypad_scanner
//   Self-checking bench for module_keypad_scanner (DEBOUNCE_TICKS = 4):
//   a directed vector table, hand-written press/overrun/reset sequences and a
//   randomized run compared against a behavioural keypad model.
//   Define KEYPAD_OVERRUN_FLAG_EN to also exercise overrun_o.
// -----------------------------------------------------------------------------
module tb_module_keypad_scanner;

   localparam int DB = 4;

   logic       clk;
   logic       rst;
   logic       tick;
   logic [3:0] row;
   logic       ack;
   logic [3:0] col;
   logic [3:0] code;
   logic       valid;
   logic       down;
`ifdef KEYPAD_OVERRUN_FLAG_EN
   logic       overrun;
`endif

   int errors = 0;
   int checks = 0;

   module_keypad_scanner #(.DEBOUNCE_TICKS(DB)) dut (
      .clk_10Mhz_i (clk),
      .reset_i     (rst),
      .scan_tick_i (tick),
      .row_i       (row),
      .key_ack_i   (ack),
      .col_o       (col),
      .key_code_o  (code),
      .key_valid_o (valid),
      .key_down_o  (down)
`ifdef KEYPAD_OVERRUN_FLAG_EN
      ,
      .overrun_o   (overrun)
`endif
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: lets the rows settle through the synchronizer on
   // non-tick cycles, then applies one cycle with the requested tick/ack.
   task automatic step(input logic t, input logic [3:0] r, input logic a);
      row  = r;
      tick = 1'b0;
      ack  = 1'b0;
      repeat (3) @(negedge clk);
      tick = t;
      ack  = a;
      @(negedge clk);
      tick = 1'b0;
      ack  = 1'b0;
   endtask

   task automatic step_n(input int n, input logic [3:0] r);
      repeat (n) step(1'b1, r, 1'b0);
   endtask

   // ---------------- behavioural reference model ----------------
   logic [3:0] m_s1, m_s2, m_pat, m_code;
   int         m_col, m_run;
   bit         m_down, m_valid, m_ovr;

   function automatic int low_count(input logic [3:0] p);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!p[i]) n++;
      return n;
   endfunction

   function automatic int low_pos(input logic [3:0] p);
      int k = 0;
      for (int i = 0; i < 4; i++) if (!p[i]) k = i;
      return k;
   endfunction

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF; m_code = 4'd0;
      m_col = 0; m_run = 0; m_down = 0; m_valid = 0; m_ovr = 0;
   endtask

   // One clock edge with inputs t/r/a present before the edge
   task automatic model_step(input logic t, input logic [3:0] r, input logic a);
      bit accepted = 0;
      if (t) begin
         if (!m_down) begin
            if (m_run == 0) begin
               if (low_count(m_s2) == 1) begin
                  m_pat = m_s2;
                  m_run = 1;
               end else begin
                  m_col = (m_col + 1) % 4;
               end
            end else if (m_s2 == m_pat) begin
               m_run++;
            end else begin
               m_run = 0;
               m_col = (m_col + 1) % 4;
            end
            if (m_run == DB) begin
               accepted = 1;
               m_down   = 1;
               m_run    = 0;
               m_code   = 4'(low_pos(m_pat) * 4 + m_col);
            end
         end else begin
            if (m_s2 == 4'hF) begin
               m_run++;
               if (m_run == DB) begin
                  m_down = 0;
                  m_run  = 0;
                  m_col  = (m_col + 1) % 4;
               end
            end else begin
               m_run = 0;
            end
         end
      end
      if (accepted) begin
         if (m_valid && !a) m_ovr = 1;
         m_valid = 1;
      end else if (a && m_valid) begin
         m_valid = 0;
         m_ovr   = 0;
      end
      m_s2 = m_s1;
      m_s1 = r;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       t;
      logic [3:0] r;
      logic       a;
      logic [3:0] col;
      logic       v;
      logic       d;
      logic [3:0] code;
   } vec_t;

   vec_t tbl [27];

   initial begin
      tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd0};
      tbl[3]  = '{1'b1, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b0, 4'd0};
      tbl[4]  = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[5]  = '{1'b1, 4'b1111, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd0};
      tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd0};
      tbl[7]  = '{1'b1, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b0, 4'd0};
      tbl[8]  = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      // press row 2 on column 1: accepted on the 4th tick, code 9
      tbl[9]  = '{1'b1, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[10] = '{1'b1, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[11] = '{1'b1, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd0};
      tbl[12] = '{1'b1, 4'b1011, 1'b0, 4'b1101, 1'b1, 1'b1, 4'd9};
      // release over 4 ticks, then scanning resumes at column 2
      tbl[13] = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b1, 1'b1, 4'd9};
      tbl[14] = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b1, 1'b1, 4'd9};
      tbl[15] = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b1, 1'b1, 4'd9};
      tbl[16] = '{1'b1, 4'b1111, 1'b0, 4'b1011, 1'b1, 1'b0, 4'd9};
      // ack on a non-tick cycle: valid clears, column holds
      tbl[17] = '{1'b0, 4'b1111, 1'b1, 4'b1011, 1'b0, 1'b0, 4'd9};
      tbl[18] = '{1'b1, 4'b1111, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd9};
      tbl[19] = '{1'b1, 4'b1111, 1'b0, 4'b1110, 1'b0, 1'b0, 4'd9};
      tbl[20] = '{1'b1, 4'b1111, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd9};
      // bounce on the 2nd tick: back to scanning, column advances
      tbl[21] = '{1'b1, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd9};
      tbl[22] = '{1'b1, 4'b1111, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd9};
      // two rows low never count as a press
      tbl[23] = '{1'b1, 4'b1001, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd9};
      tbl[24] = '{1'b1, 4'b1001, 1'b0, 4'b1110, 1'b0, 1'b0, 4'd9};
      tbl[25] = '{1'b1, 4'b1001, 1'b0, 4'b1101, 1'b0, 1'b0, 4'd9};
      tbl[26] = '{1'b1, 4'b1001, 1'b0, 4'b1011, 1'b0, 1'b0, 4'd9};
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] rnd_row;
      int         hold_left;
      logic       rt, ra;

      rst = 1'b1; tick = 1'b0; row = 4'hF; ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_col",   8'(col),   8'b1110);
      check("reset_code",  8'(code),  8'd0);
      check("reset_valid", 8'(valid), 8'd0);
      check("reset_down",  8'(down),  8'd0);
`ifdef KEYPAD_OVERRUN_FLAG_EN
      check("reset_overrun", 8'(overrun), 8'd0);
`endif

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].t, tbl[i].r, tbl[i].a);
         check($sformatf("tbl%0d_col", i),   8'(col),   8'(tbl[i].col));
         check($sformatf("tbl%0d_valid", i), 8'(valid), 8'(tbl[i].v));
         check($sformatf("tbl%0d_down", i),  8'(down),  8'(tbl[i].d));
         check($sformatf("tbl%0d_code", i),  8'(code),  8'(tbl[i].code));
      end

      // First press at column 2, row 3: not yet accepted after 3 ticks
      step_n(3, 4'b0111);
      check("lat3_valid", 8'(valid), 8'd0);
      step_n(1, 4'b0111);
      check("k1_valid", 8'(valid), 8'd1);
      check("k1_code",  8'(code),  8'd14);
      step_n(4, 4'b1111);
      check("k1_rel_down", 8'(down), 8'd0);
      check("k1_rel_col",  8'(col),  8'b0111);
      // Second press at column 3, row 0, without acknowledging the first
      step_n(4, 4'b1110);
      check("k2_valid", 8'(valid), 8'd1);
      check("k2_code",  8'(code),  8'd3);
`ifdef KEYPAD_OVERRUN_FLAG_EN
      check("k2_overrun", 8'(overrun), 8'd1);
`endif
      step(1'b0, 4'b1110, 1'b1);
      check("k2_ack_valid", 8'(valid), 8'd0);
      check("k2_ack_down",  8'(down),  8'd1);
`ifdef KEYPAD_OVERRUN_FLAG_EN
      check("k2_ack_overrun", 8'(overrun), 8'd0);
`endif
      step_n(4, 4'b1111);
      check("k2_rel_col", 8'(col), 8'b1110);
      // Third key (column 0, row 1) left pending, then reset mid-debounce
      step_n(4, 4'b1101);
      check("k3_code", 8'(code), 8'd4);
      step_n(4, 4'b1111);
      step_n(2, 4'b0111);
      check("pre_rst_col", 8'(col), 8'b1101);
      #13 rst = 1'b1;
      #1;
      check("async_rst_col",   8'(col),   8'b1110);
      check("async_rst_code",  8'(code),  8'd0);
      check("async_rst_valid", 8'(valid), 8'd0);
      check("async_rst_down",  8'(down),  8'd0);
`ifdef KEYPAD_OVERRUN_FLAG_EN
      check("async_rst_overrun", 8'(overrun), 8'd0);
`endif
      row = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Randomized run against the model
      hold_left = 0;
      rnd_row   = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         check("rand_col",   8'(col),   8'(4'hF ^ (4'd1 << m_col)));
         check("rand_code",  8'(code),  8'(m_code));
         check("rand_valid", 8'(valid), 8'(m_valid));
         check("rand_down",  8'(down),  8'(m_down));
`ifdef KEYPAD_OVERRUN_FLAG_EN
         check("rand_overrun", 8'(overrun), 8'(m_ovr));
`endif
         if (hold_left == 0) begin
            case ($urandom_range(0, 19))
               0, 1, 2, 3, 4, 5, 6, 7, 8, 9: rnd_row = 4'hF;
               10, 11, 12, 13, 14, 15, 16:   rnd_row = 4'hF ^ (4'd1 << $urandom_range(0, 3));
               default:                      rnd_row = 4'($urandom_range(0, 15));
            endcase
            hold_left = $urandom_range(1, 40);
         end
         hold_left--;
         rt   = ($urandom_range(0, 2) == 0);
         ra   = ($urandom_range(0, 9) == 0);
         row  = rnd_row;
         tick = rt;
         ack  = ra;
         model_step(rt, rnd_row, ra);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
